branch_compare_iter: RTL and testbench

Parametrised, multi-cycle magnitude/equality comparator for the integer datapath. It evaluates the RISC-V branch and set-less-than conditions (EQ, NE, LT, GE, LTU, GEU) on WIDTH-bit operands, CHUNK bits per cycle, starting from the MSB end. It sits between the decode/issue stage and branch resolution / SLT writeback, with valid/ready handshakes on both sides and a flush input for misprediction recovery.

---
 rtl/branch_compare_iter.sv | 129 ++++++++++++
 tb/tb_branch_compare_iter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_iter.sv
// Multi-cycle RISC-V branch/SLT comparator: scans operands CHUNK bits per cycle from the MSB end
// and reports EQ/NE/LT/GE/LTU/GEU through a valid/ready result port.
module branch_compare_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        op_q;
  logic [IdxW-1:0]   idx_q;
  logic              lt_q;
  logic              seen_q;

  logic              signed_op;
  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    sum;
  logic              chunk_diff, chunk_lt;
  logic              lt_fin, eq_fin, finish, taken_d;

  assign o_ready   = (state_q == StIdle) && !i_flush;
  assign o_result  = WIDTH'(o_taken);
  assign signed_op = i_op[2] & ~i_op[1];

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    // a + ~b + 1: carry-out set means a >= b (unsigned), zero sum means equal
    sum        = {1'b0, a_chunk} + {1'b0, ~b_chunk} + (CHUNK + 1)'(1);
    chunk_diff = |sum[CHUNK-1:0];
    chunk_lt   = ~sum[CHUNK];
    finish     = (idx_q == '0) || (EARLY_EXIT && chunk_diff);

    // Only the most significant differing chunk decides the ordering
    if (seen_q) begin
      lt_fin = lt_q;
      eq_fin = 1'b0;
    end else if (chunk_diff) begin
      lt_fin = chunk_lt;
      eq_fin = 1'b0;
    end else begin
      lt_fin = 1'b0;
      eq_fin = 1'b1;
    end

    taken_d = 1'b0;
    case (op_q)
      3'b000:         taken_d = eq_fin;
      3'b001:         taken_d = ~eq_fin;
      3'b100, 3'b110: taken_d = lt_fin;
      3'b101, 3'b111: taken_d = ~lt_fin;
      default:        taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      o_valid <= 1'b0;
      o_taken <= 1'b0;
      idx_q   <= IdxW'(N - 1);
    end else if (i_flush) begin
      state_q <= StIdle;
      o_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            // Flipping both sign bits turns a signed compare into an unsigned one
            a_q     <= i_a ^ (signed_op ? MsbMask : '0);
            b_q     <= i_b ^ (signed_op ? MsbMask : '0);
            op_q    <= i_op;
            idx_q   <= IdxW'(N - 1);
            seen_q  <= 1'b0;
            lt_q    <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (chunk_diff && !seen_q) begin
            seen_q <= 1'b1;
            lt_q   <= chunk_lt;
          end
          if (finish) begin
            state_q <= StDone;
            o_valid <= 1'b1;
            o_taken <= taken_d;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
            o_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_compare_iter.sv
// Scoreboard bench for branch_compare_iter: one early-exit and one full-scan instance share stimulus.
module tb_branch_compare_iter;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  typedef struct {
    logic taken;
    int   lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         rdy_in = 1'b1;

  logic         ready1, valid1, taken1;
  logic [W-1:0] result1;
  logic         ready0, valid0, taken0;
  logic [W-1:0] result0;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc1 = 0;
  int   acc0 = 0;
  logic shown1 = 1'b0;
  logic shown0 = 1'b0;
  exp_t q1[$];
  exp_t q0[$];

  branch_compare_iter #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_valid(valid), .o_ready(ready1),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(valid1), .i_ready(rdy_in), .o_taken(taken1),
    .o_result(result1)
  );

  branch_compare_iter #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(1'b0)) dut_full (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_valid(valid), .o_ready(ready0),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(valid0), .i_ready(rdy_in), .o_taken(taken0),
    .o_result(result0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_taken(input logic [2:0] o, input logic [W-1:0] x, y);
    case (o)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) < $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x < y;
      3'b111:  return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, y);
    for (int k = N - 1; k >= 0; k--) begin
      if (x[k*C +: C] != y[k*C +: C]) return N - k + 1;
    end
    return N + 1;
  endfunction

  // Scoreboard: note accepts, pop and compare on each rising result
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset && valid && ready1) acc1 = cyc;
    if (!reset && valid && ready0) acc0 = cyc;
    if (valid1 && !shown1) begin
      shown1 = 1'b1;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL ee_unexpected_result got=valid exp=no result");
      end else begin
        e = q1.pop_front();
        if (taken1 !== e.taken) begin
          errors++;
          $display("FAIL ee_taken got=%0b exp=%0b", taken1, e.taken);
        end
        checks++;
        if (result1 !== {{(W-1){1'b0}}, e.taken}) begin
          errors++;
          $display("FAIL ee_result got=%h exp=%h", result1, {{(W-1){1'b0}}, e.taken});
        end
        checks++;
        if (cyc - acc1 != e.lat) begin
          errors++;
          $display("FAIL ee_latency got=%0d exp=%0d", cyc - acc1, e.lat);
        end
      end
    end
    if (!valid1) shown1 = 1'b0;
    if (valid0 && !shown0) begin
      shown0 = 1'b1;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL full_unexpected_result got=valid exp=no result");
      end else begin
        e = q0.pop_front();
        if (taken0 !== e.taken) begin
          errors++;
          $display("FAIL full_taken got=%0b exp=%0b", taken0, e.taken);
        end
        checks++;
        if (cyc - acc0 != e.lat) begin
          errors++;
          $display("FAIL full_latency got=%0d exp=%0d", cyc - acc0, e.lat);
        end
      end
    end
    if (!valid0) shown0 = 1'b0;
  end

  task automatic wait_ready();
    for (int i = 0; i < 40 && !(ready1 && ready0); i++) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge clk);
    wait_ready();
    op = o; a = x; b = y; valid = 1'b1;
    e.taken = model_taken(o, x, y);
    e.lat = model_lat(x, y);
    q1.push_back(e);
    e.lat = N + 1;
    q0.push_back(e);
    @(negedge clk);
    valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (q1.size() != 0 || q0.size() != 0); i++) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q0.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d/%0d pending exp=0", q1.size(), q0.size());
      q1.delete();
      q0.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rdy_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%0b%0b exp=11", ready1, ready0);
    end
    checks++;
    if (valid1 !== 1'b0 || valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%0b%0b exp=00", valid1, valid0);
    end
    checks++;
    if (taken1 !== 1'b0 || result1 !== '0) begin
      errors++;
      $display("FAIL reset_result got=%0b/%h exp=0/0", taken1, result1);
    end
  endtask

  task automatic test_directed();
    send(3'b110, 32'h0000_0001, 32'hFFFF_FFFF);  // LTU taken, MSB chunk differs
    send(3'b100, 32'h0000_0001, 32'hFFFF_FFFF);  // LT: +1 < -1 is false
    send(3'b101, 32'h0000_0001, 32'hFFFF_FFFF);
    send(3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send(3'b001, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    send(3'b111, 32'h1234_5678, 32'h1234_5679);
    send(3'b010, 32'h0000_0001, 32'hFFFF_FFFF);  // reserved
    send(3'b011, 32'h5555_5555, 32'h5555_5555);  // reserved
    send(3'b100, 32'h8000_0000, 32'h7FFF_FFFF);
    send(3'b111, 32'h0000_0100, 32'h0000_0100);
    drain();
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] x, y;
    int           k;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      case ($urandom_range(0, 2))
        0: y = x;
        1: begin
          k = $urandom_range(0, N - 1);
          y = x ^ (32'($urandom_range(1, 255)) << (C * k));
        end
        default: y = $urandom;
      endcase
      send(o, x, y);
    end
    drain();
  endtask

  task automatic test_backpressure();
    rdy_in = 1'b0;
    send(3'b111, 32'h1234_5678, 32'h1234_5679);
    for (int i = 0; i < 20 && !valid1; i++) @(negedge clk);
    checks++;
    if (valid1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_rise got=%0b exp=1", valid1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (valid1 !== 1'b1 || taken1 !== 1'b0 || ready1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got=v%0b t%0b r%0b exp=v1 t0 r0", valid1, taken1, ready1);
      end
    end
    rdy_in = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got=r%0b v%0b exp=r1 v0", ready1, valid1);
    end
    drain();
  endtask

  task automatic test_abort(input logic use_reset);
    int seen;
    // Leave o_taken at 1 so a reset abort must visibly clear it
    send(3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D);
    drain();
    @(negedge clk);
    wait_ready();
    op = 3'b000; a = 32'h0BAD_CAFE; b = 32'h0BAD_CAFE; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || ready0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle(rst=%0b) got=r%0b v%0b r0=%0b exp=r1 v0 r0=1",
               use_reset, ready1, valid1, ready0);
    end
    if (use_reset) begin
      checks++;
      if (taken1 !== 1'b0 || result1 !== '0) begin
        errors++;
        $display("FAIL abort_reset_taken got=%0b/%h exp=0/0", taken1, result1);
      end
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid1 || valid0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result(rst=%0b) got=%0d valid cycles exp=0", use_reset, seen);
    end
  endtask

  task automatic test_flush_idle();
    int seen;
    @(negedge clk);
    wait_ready();
    flush = 1'b1; valid = 1'b1; op = 3'b000; a = 32'h1; b = 32'h1;
    #1;
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready got=%0b exp=0", ready1);
    end
    @(negedge clk);
    valid = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_accepted got=ready %0b exp=1", ready1);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid1 || valid0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_idle_no_result got=%0d exp=0", seen);
    end
  endtask

  task automatic test_back_to_back(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    exp_t e;
    int   first, second;
    first = -1;
    second = -1;
    @(negedge clk);
    wait_ready();
    op = o; a = x; b = y; valid = 1'b1;
    e.taken = model_taken(o, x, y);
    for (int n = 0; n < 40 && second < 0; n++) begin
      #1;
      if (ready1) begin
        e.lat = model_lat(x, y);
        q1.push_back(e);
        if (first < 0) first = n;
        else second = n;
      end
      if (ready0) begin
        e.lat = N + 1;
        q0.push_back(e);
      end
      @(negedge clk);
    end
    valid = 1'b0;
    checks++;
    if (second - first != model_lat(x, y) + 1) begin
      errors++;
      $display("FAIL b2b_interval got=%0d exp=%0d", second - first, model_lat(x, y) + 1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_flush_idle();
    test_back_to_back(3'b110, 32'h0000_0001, 32'hFFFF_FFFF);
    test_back_to_back(3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
